fifo_wr_arbiter: RTL and testbench

//  Shares the write port of one FIFO (the fifo_async write side) between NUM_REQ requesters.

---
 rtl/fifo_ctrl_pkg.sv | 22 ++
 rtl/rr_pick.sv | 50 +++++
 rtl/fifo_wr_arbiter.sv | 144 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ctrl_pkg
// Description : Shared definitions for the FIFO write-side controller slice:
//               arbiter state encoding and owner-index width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_ctrl_pkg;

    // Write-port arbiter states
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    // Width of an index into n requesters; never less than one bit
    function automatic int own_width(input int n);
        return ($clog2(n) > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotating-priority picker. Returns the first
//               asserted request found searching upward from 'base',
//               wrapping from NUM_REQ-1 back to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   base,
    output logic               hit,
    output logic [IDX_W-1:0]   idx
);

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [IDX_W-1:0]     w_offset;
    logic [IDX_W:0]       w_sum;

    // Rotate the request vector so bit 0 corresponds to 'base'
    assign w_dbl = {req, req} >> base;
    assign w_rot = w_dbl[NUM_REQ-1:0];

    // Scan offsets from high to low so the smallest offset from base wins
    always_comb begin
        hit      = 1'b0;
        w_offset = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                hit      = 1'b1;
                w_offset = IDX_W'(k);
            end
        end
    end

    // Map the rotated offset back to an absolute requester index
    always_comb begin
        w_sum = {1'b0, base} + {1'b0, w_offset};
        if (w_sum >= (IDX_W + 1)'(NUM_REQ)) begin
            w_sum = w_sum - (IDX_W + 1)'(NUM_REQ);
        end
        idx = w_sum[IDX_W-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin burst arbiter sharing one FIFO write port among
//               NUM_REQ requesters. A winner keeps the port for up to
//               BURST_LEN beats; beats are back-pressured by fifo_full.
//               A sticky flag records any FIFO write-error pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int WIDTH     = 8,
    parameter  int BURST_LEN = 4,
    localparam int OWN_W     = own_width(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       gnt,
    input  logic                     fifo_full,
    input  logic                     fifo_wr_err,
    output logic                     fifo_wr_en,
    output logic [WIDTH-1:0]         fifo_wdata,
    output logic [OWN_W-1:0]         owner,
    output logic                     busy,
    output logic                     wr_err_seen
);

    localparam int                 c_cnt_w     = $clog2(BURST_LEN) + 1;
    localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(BURST_LEN - 1);
    localparam logic [OWN_W-1:0]   c_top_idx   = OWN_W'(NUM_REQ - 1);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [OWN_W-1:0]   r_owner;
    logic [OWN_W-1:0]   w_owner_nxt;
    logic [OWN_W-1:0]   r_last_owner;
    logic [OWN_W-1:0]   w_last_owner_nxt;
    logic [c_cnt_w-1:0] r_beat_cnt;
    logic [c_cnt_w-1:0] w_beat_cnt_nxt;
    logic               r_wr_err_seen;

    logic [OWN_W-1:0]   w_base;
    logic               w_pick_hit;
    logic [OWN_W-1:0]   w_pick_idx;
    logic               w_owner_req;
    logic [WIDTH-1:0]   w_owner_data;

    // Search starts one past the previous winner so priority rotates
    assign w_base = (r_last_owner == c_top_idx) ? '0 : (r_last_owner + OWN_W'(1));

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (OWN_W)
    ) u_rr_pick (
        .req  (req),
        .base (w_base),
        .hit  (w_pick_hit),
        .idx  (w_pick_idx)
    );

    // Select the current owner's request bit and data slice
    always_comb begin
        w_owner_req  = 1'b0;
        w_owner_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_owner == OWN_W'(i)) begin
                w_owner_req  = req[i];
                w_owner_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state and write-port outputs; a beat is accepted combinationally
    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_last_owner_nxt = r_last_owner;
        w_beat_cnt_nxt   = r_beat_cnt;
        gnt              = '0;
        fifo_wr_en       = 1'b0;
        fifo_wdata       = '0;
        case (r_state)
            ST_IDLE: begin
                // Arbitration bubble: choose the winner, write nothing
                if (w_pick_hit) begin
                    w_state_nxt      = ST_BURST;
                    w_owner_nxt      = w_pick_idx;
                    w_last_owner_nxt = w_pick_idx;
                    w_beat_cnt_nxt   = '0;
                end
            end
            ST_BURST: begin
                if (!w_owner_req) begin
                    // Owner released early; give the port back
                    w_state_nxt = ST_IDLE;
                end else if (!fifo_full) begin
                    fifo_wr_en = 1'b1;
                    fifo_wdata = w_owner_data;
                    gnt        = NUM_REQ'(1) << r_owner;
                    if (r_beat_cnt == c_last_beat) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + c_cnt_w'(1);
                    end
                end
                // fifo_full with request held: stall, everything holds
            end
        endcase
    end

    // Arbiter state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= '0;
            r_last_owner <= c_top_idx;
            r_beat_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_beat_cnt   <= w_beat_cnt_nxt;
        end
    end

    // Sticky record of any FIFO write-error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_err_seen <= 1'b0;
        end else if (fifo_wr_err) begin
            r_wr_err_seen <= 1'b1;
        end
    end

    assign owner       = r_owner;
    assign busy        = (r_state == ST_BURST);
    assign wr_err_seen = r_wr_err_seen;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Self-checking bench for fifo_wr_arbiter: directed scenarios
//               with literal expectations, then randomized traffic compared
//               every cycle against a behavioural round-robin model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int WIDTH     = 8;
    localparam int BURST_LEN = 4;
    localparam int DEPTH     = 16;

    logic        clk         = 1'b0;
    logic        rst         = 1'b1;
    logic [3:0]  req         = '0;
    logic [31:0] req_data    = '0;
    logic        fifo_full   = 1'b0;
    logic        fifo_wr_err = 1'b0;
    logic [3:0]  gnt;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wdata;
    logic [1:0]  owner;
    logic        busy;
    logic        wr_err_seen;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state: who holds the port, beats written so far
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_last  = NUM_REQ - 1;
    int m_beats = 0;
    bit m_err   = 1'b0;
    logic [3:0] last_gnt = '0;

    // Directed expectation tables
    logic [3:0] exp2  [10] = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h4, 4'h4, 4'h4, 4'h4};
    logic [3:0] exp4  [9]  = '{4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0};
    logic       full4 [9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0] req5  [10] = '{4'h9, 4'h9, 4'h9, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8};
    logic [3:0] exp5  [10] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h8, 4'h8, 4'h8, 4'h8, 4'h0};
    int         seq3  [5]  = '{0, 1, 2, 3, 0};

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .WIDTH     (WIDTH),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .gnt         (gnt),
        .fifo_full   (fifo_full),
        .fifo_wr_err (fifo_wr_err),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_wdata  (fifo_wdata),
        .owner       (owner),
        .busy        (busy),
        .wr_err_seen (wr_err_seen)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs are driven 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Model compare: check outputs at the falling edge, then advance the model
    initial begin
        logic       e_acc;
        logic [3:0] e_gnt;
        logic [7:0] e_data;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_busy  = 1'b0;
                m_owner = 0;
                m_last  = NUM_REQ - 1;
                m_beats = 0;
                m_err   = 1'b0;
            end
            e_acc  = m_busy && req[m_owner] && !fifo_full;
            e_gnt  = e_acc ? 4'(1 << m_owner) : 4'h0;
            e_data = e_acc ? req_data[m_owner*WIDTH +: WIDTH] : 8'h00;
            check("model_gnt", 32'(gnt), 32'(e_gnt));
            check("model_wr_en", 32'(fifo_wr_en), 32'(e_acc));
            check("model_wdata", 32'(fifo_wdata), 32'(e_data));
            check("model_owner", 32'(owner), 32'(m_owner));
            check("model_busy", 32'(busy), 32'(m_busy));
            check("model_err_seen", 32'(wr_err_seen), 32'(m_err));
            last_gnt = gnt;
            if (!rst) begin
                if (!m_busy) begin
                    for (int k = 1; k <= NUM_REQ; k++) begin
                        if (!m_busy && req[(m_last + k) % NUM_REQ]) begin
                            m_busy  = 1'b1;
                            m_owner = (m_last + k) % NUM_REQ;
                            m_last  = m_owner;
                            m_beats = 0;
                        end
                    end
                end else if (!req[m_owner]) begin
                    m_busy = 1'b0;
                end else if (!fifo_full) begin
                    m_beats++;
                    if (m_beats == BURST_LEN) m_busy = 1'b0;
                end
                if (fifo_wr_err) m_err = 1'b1;
            end
        end
    end

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    // Stimulus and literal expectations
    initial begin
        int occ;
        bit ovf;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Lone requester 2: bubble, 4 beats, bubble, 4 beats
        req      = 4'b0100;
        req_data = 32'h00A5_0000;
        for (int c = 0; c < 10; c++) begin
            #3;
            check("lone_gnt", 32'(gnt), 32'(exp2[c]));
            check("lone_wdata", 32'(fifo_wdata), (exp2[c] != 4'h0) ? 32'hA5 : 32'h0);
            tick();
        end
        req = '0;
        reset_pulse();

        // Reset mid-burst with no clock edge, owner 1 busy and error seen
        req         = 4'b0010;
        req_data    = 32'h1312_1110;
        fifo_wr_err = 1'b1;
        tick();
        fifo_wr_err = 1'b0;
        #3;
        check("pre_rst_gnt", 32'(gnt), 32'h2);
        tick();
        #1;
        check("pre_rst_owner", 32'(owner), 32'd1);
        check("pre_rst_err", 32'(wr_err_seen), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_wr_en", 32'(fifo_wr_en), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_owner", 32'(owner), 32'h0);
        check("rst_err", 32'(wr_err_seen), 32'h0);
        check("rst_wdata", 32'(fifo_wdata), 32'h0);
        tick();
        req = 4'b1111;
        rst = 1'b0;

        // All requesting: owners 0,1,2,3,0 with 4 beats each
        for (int c = 0; c < 25; c++) begin
            #3;
            if (c % 5 == 0) begin
                check("rr_bubble_gnt", 32'(gnt), 32'h0);
            end else begin
                check("rr_gnt", 32'(gnt), 32'(1 << seq3[c/5]));
                check("rr_owner", 32'(owner), 32'(seq3[c/5]));
                check("rr_wdata", 32'(fifo_wdata), 32'h10 + 32'(seq3[c/5]));
            end
            tick();
        end
        req = '0;
        reset_pulse();

        // Owner 1 stalled by fifo_full for 3 cycles mid-burst
        req      = 4'b0010;
        req_data = 32'h0000_3C00;
        for (int c = 0; c < 9; c++) begin
            fifo_full = full4[c];
            #3;
            check("stall_gnt", 32'(gnt), 32'(exp4[c]));
            check("stall_wr_en", 32'(fifo_wr_en), 32'(exp4[c] != 4'h0));
            tick();
        end
        fifo_full = 1'b0;
        req       = '0;
        reset_pulse();

        // Owner 0 releases early; requester 3 wins next, skipping 1 and 2
        req_data = 32'h5300_0050;
        for (int c = 0; c < 10; c++) begin
            req = req5[c];
            #3;
            check("release_gnt", 32'(gnt), 32'(exp5[c]));
            if (c >= 5 && c <= 8) check("release_owner", 32'(owner), 32'd3);
            tick();
        end
        req = '0;
        reset_pulse();

        // Error pulse is sticky; FIFO of DEPTH fills exactly, never overruns
        req      = 4'b1111;
        req_data = 32'h4433_2211;
        occ      = 0;
        ovf      = 1'b0;
        for (int c = 0; c < 40; c++) begin
            fifo_full   = (occ == DEPTH);
            fifo_wr_err = (c == 0);
            #3;
            if (fifo_wr_en) begin
                if (occ == DEPTH) ovf = 1'b1;
                occ++;
            end
            if (c == 1 || c == 39) check("err_sticky", 32'(wr_err_seen), 32'd1);
            tick();
        end
        fifo_wr_err = 1'b0;
        check("fill_count", 32'(occ), 32'(DEPTH));
        check("fill_no_overrun", 32'(ovf), 32'd0);
        check("fill_held_off", 32'(fifo_wr_en), 32'd0);
        fifo_full = 1'b0;
        req       = '0;
        reset_pulse();
        #1;
        check("err_cleared", 32'(wr_err_seen), 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req[i] && last_gnt[i]) begin
                    req_data[i*WIDTH +: WIDTH] = 8'($urandom);
                    req[i] = ($urandom_range(0, 3) != 0);
                end else if (req[i]) begin
                    if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                    req_data[i*WIDTH +: WIDTH] = 8'($urandom);
                end
            end
            fifo_full   = ($urandom_range(0, 4) == 0);
            fifo_wr_err = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #1;
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
